// File: rtl/conv_column_packer.sv
// Streaming column assembler for the max-pooling stage.
// Pixels arrive column-major; each completed column is presented for one cycle.
module conv_column_packer #(
  parameter int unsigned HEIGHT = 24,
  parameter int unsigned WIDTH  = 24,
  parameter int unsigned DATA_W = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic                          abort,
  input  logic                          pixel_valid,
  output logic                          pixel_ready,
  input  logic [DATA_W-1:0]             pixel_data,
  output logic                          valid_out,
  output logic [HEIGHT-1:0][DATA_W-1:0] output_column,
  output logic [$clog2(WIDTH)-1:0]      column_idx,
  output logic                          frame_done
);

  localparam int unsigned ROW_W = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam int unsigned COL_W = $clog2(WIDTH);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(HEIGHT - 1);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(WIDTH - 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_FILL = 1'b1
  } state_e;

  state_e                          state_q, state_d;
  logic [ROW_W-1:0]                row_cnt_q, row_cnt_d;
  logic [COL_W-1:0]                col_cnt_q, col_cnt_d;
  logic [HEIGHT-1:0][DATA_W-1:0]   assembly_q, assembly_d;
  logic [HEIGHT-1:0][DATA_W-1:0]   out_col_q, out_col_d;
  logic [COL_W-1:0]                col_idx_q, col_idx_d;
  logic                            valid_q, valid_d;
  logic                            done_q, done_d;
  logic                            ready_q, ready_d;

  // Next-state, datapath and strobe generation
  always_comb begin
    state_d    = state_q;
    row_cnt_d  = row_cnt_q;
    col_cnt_d  = col_cnt_q;
    assembly_d = assembly_q;
    out_col_d  = out_col_q;
    col_idx_d  = col_idx_q;
    valid_d    = 1'b0;
    done_d     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        // A start landing on the frame_done cycle is not honoured; the next
        // frame begins no earlier than the cycle after frame_done.
        if (start && !abort && !done_q) begin
          state_d   = S_FILL;
          row_cnt_d = '0;
          col_cnt_d = '0;
        end
      end
      S_FILL: begin
        if (abort) begin
          state_d   = S_IDLE;
          row_cnt_d = '0;
          col_cnt_d = '0;
        end else if (pixel_valid) begin
          assembly_d[row_cnt_q] = pixel_data;
          if (row_cnt_q == ROW_LAST) begin
            out_col_d = assembly_d;
            col_idx_d = col_cnt_q;
            valid_d   = 1'b1;
            row_cnt_d = '0;
            if (col_cnt_q == COL_LAST) begin
              done_d    = 1'b1;
              col_cnt_d = '0;
              state_d   = S_IDLE;
            end else begin
              col_cnt_d = col_cnt_q + COL_W'(1);
            end
          end else begin
            row_cnt_d = row_cnt_q + ROW_W'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    ready_d = (state_d == S_FILL);
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      row_cnt_q  <= '0;
      col_cnt_q  <= '0;
      assembly_q <= '0;
      out_col_q  <= '0;
      col_idx_q  <= '0;
      valid_q    <= 1'b0;
      done_q     <= 1'b0;
      ready_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      row_cnt_q  <= row_cnt_d;
      col_cnt_q  <= col_cnt_d;
      assembly_q <= assembly_d;
      out_col_q  <= out_col_d;
      col_idx_q  <= col_idx_d;
      valid_q    <= valid_d;
      done_q     <= done_d;
      ready_q    <= ready_d;
    end
  end

  assign pixel_ready   = ready_q;
  assign valid_out     = valid_q;
  assign frame_done    = done_q;
  assign output_column = out_col_q;
  assign column_idx    = col_idx_q;

endmodule

// File: doc/conv_column_packer.md
# conv_column_packer

Streaming feeder for the max-pooling stage. Accepts a convolution feature map one pixel per cycle in column-major order (valid/ready) and assembles each column of HEIGHT pixels into a packed column vector. It presents each completed column with a one-cycle `valid_out` strobe, matching the `valid_in` / `input_column` interface of the pooling layer. Frame sequencing (start, abort, done) is handled here so the pooling stage always sees whole, correctly paired column sequences.

## Interface
- `HEIGHT`, default 24: pixels per column; equals the pooling layer input column height.
- `WIDTH`, default 24: columns per frame; must be even so 2x2 pooling pairs columns within a frame.
- `DATA_W`, default 16: pixel width in bits.

- `clk`  in  1  single clock; all logic on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle pulse; begins a frame when the block is IDLE.
- `abort`  in  1  synchronous frame abort.
- `pixel_valid`  in  1  upstream pixel valid.
- `pixel_ready`  out  1  block can accept a pixel.
- `pixel_data`  in  DATA_W  pixel value; signed two's complement, passed through unmodified.
- `valid_out`  out  1  one-cycle strobe: `output_column` holds a new complete column.
- `output_column`  out  [HEIGHT-1:0][DATA_W-1:0]  packed column; index 0 is the first pixel received (top row).
- `column_idx`  out  $clog2(WIDTH)  index of the column currently on `output_column`.
- `frame_done`  out  1  one-cycle strobe, coincident with `valid_out` of column WIDTH-1.

## Operation
- FSM with two states.
  - IDLE: `pixel_ready`=0. `start`=1 (and `abort`=0) -> FILL, with `row_cnt` and `col_cnt` cleared.
  - FILL: `pixel_ready`=1.
- A pixel is accepted when `pixel_valid` & `pixel_ready`. It is written to `assembly[row_cnt]`, then `row_cnt` increments.
- Column completion: on accepting the pixel with `row_cnt`=HEIGHT-1:
  - the next cycle loads `output_column` with the full column (including this last pixel);
  - `column_idx` is set to `col_cnt`, and `valid_out`=1;
  - `row_cnt` resets to 0 and `col_cnt` increments.
- Frame completion: when the completed column has `col_cnt`=WIDTH-1, `frame_done`=1 in that same `valid_out` cycle, `col_cnt` wraps to 0, and the FSM returns to IDLE.
- The assembly buffer is separate from the `output_column` register. Pixels keep being accepted on the cycle `valid_out` is high; there are no bubbles between columns.
- `output_column` and `column_idx` hold their value until the next column completes.
- `start` in FILL is ignored.
- `abort` in FILL -> IDLE. `row_cnt` and `col_cnt` clear, the partial column is discarded, and neither `valid_out` nor `frame_done` is generated.
- `abort` in IDLE: stay IDLE; it wins over a simultaneous `start`.
- `abort` in the same cycle as the last pixel of a column is accepted: the abort wins, and no `valid_out` follows.
- `pixel_valid` while in IDLE: ignored, nothing accepted.

## Timing
- Reset (`rst`=0, asynchronous): FSM=IDLE, counters=0, `pixel_ready`=0, `valid_out`=0, `frame_done`=0, `column_idx`=0, `output_column`=all zeros.
- `pixel_ready` is a registered state decode. It is 1 starting the cycle after `start` is sampled.
- Latency: 1 cycle from acceptance of a column's last pixel to `valid_out`.
- Throughput: one pixel per cycle; a sustained stream yields `valid_out` every HEIGHT cycles.
- A full frame takes HEIGHT*WIDTH accept cycles, and `frame_done` follows 1 cycle after the final accept.
- After `frame_done`, `pixel_ready`=0 until the next `start`. That earliest `start` is sampled in the cycle after `frame_done`.
- `valid_out` and `frame_done` are registered, never held longer than one cycle, and not combinationally dependent on inputs.
- Mid-operation reset clears all state immediately. No `valid_out` is produced for the in-flight column.

## Test plan
- **Reset and idle.** Assert `rst`=0 mid-stream, release it, then drive `pixel_valid`=1 without `start` -> all outputs zero, `pixel_ready`=0, no `valid_out`.
- **Single column.** Pulse `start`, then stream pixels 1..24 back-to-back -> one cycle after pixel 24 is accepted, `valid_out`=1, `output_column[0]`=1, `output_column[23]`=24, `column_idx`=0, `frame_done`=0.
- **Full frame.** Stream 576 pixels, value = col*24+row, continuously -> 24 `valid_out` strobes spaced 24 cycles apart, `column_idx` 0..23, and `frame_done`=1 only with column 23. Then `pixel_ready`=0 and the FSM is IDLE.
- **Gapped input.** Apply random `pixel_valid` gaps (~50% duty) and negative values (e.g. 16'hFFFE) -> columns bit-identical to the gapless run, with `valid_out` exactly 1 cycle after each 24th accept.
- **Abort.** `abort` after 30 pixels -> exactly one `valid_out` (column 0), then IDLE. A new `start` plus a full frame yields `column_idx` starting at 0. Also apply `abort` coincident with the 24th pixel of a column -> no `valid_out` for that column.
- **Start during FILL.** Pulse `start` in FILL -> ignored; counters unaffected and frame output unchanged.
